cordic: RTL and testbench
=========================

# cordic

Fixed-point rotation-mode CORDIC that produces cosine and sine of an input angle given in degrees. It is a fully pipelined 10-iteration block that accepts one angle per clock and returns (cos, sin, residual angle) a fixed 10 cycles later. It serves the team's numerically controlled oscillator and mixer datapath as the angle-to-I/Q converter.

## Interface
- `N`, default 10: number of CORDIC iterations, which equals the number of pipeline stages. Only 10 is supported, because the arctangent table is sized for it.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `in_valid`  input  1: `z0` is valid this cycle.
- `z0`  input  11: angle in degrees, unsigned Q7.4 (LSB = 1/16°). For example, 720 = 45.0°.
- `out_valid`  output  1: `xn`/`yn`/`zn` hold a result this cycle.
- `xn`  output  17: cosine, unsigned Q0.17 (value/131072).
- `yn`  output  17: sine, unsigned Q0.17.
- `zn`  output  11: residual angle, signed two's-complement Q6.4 degrees.

## Operation
- Input conditioning: `z0` values above 1440 (90°) are clamped to 1440. The result is held internally as a 12-bit signed angle.
- Initial vector: x0 = 79594 (K ≈ 0.6072529 × 2^17), y0 = 0, z = the conditioned angle.
- Internal x/y datapath: 20-bit signed, consisting of a sign bit, 17 fraction bits, and 2 guard bits below the LSB.
- Iteration i, for i = 0 to 9:
  - d = +1 if z ≥ 0, otherwise d = −1.
  - x' = x − d·(y >>> i)
  - y' = y + d·(x >>> i)
  - z' = z − d·atan_i
  - Shifts are arithmetic.
- atan_i table, in Q.4 degrees: 720, 425, 225, 114, 57, 29, 14, 7, 4, 2.
- Output conversion:
  - Drop the guard bits (see Configuration).
  - Clamp x and y to the range 0–131071. Negative values become 0; values ≥ 2^17 become 131071, so 0° yields `xn` = 131071.
  - `zn` = the final z truncated to 11 bits. Its magnitude is always < 64°, so no overflow occurs.
- Accuracy: over 0–90°, |xn − cos·2^17| ≤ 400 LSB and |yn − sin·2^17| ≤ 400 LSB.

## Timing
- Fully pipelined; throughput is one angle per cycle; no back-pressure.
- `in_valid`/`z0` are sampled at edge t. The matching `out_valid`/`xn`/`yn`/`zn` appear after edge t+10, so latency is 10 cycles.
- `out_valid` is a 10-deep shift of `in_valid`.
- Data registers advance every cycle regardless of valid. Outputs are don't-care while `out_valid` = 0, but they must never be X after reset.
- Reset behaviour:
  - While `rst_n` = 0, all pipeline registers clear immediately, independent of `clk`.
  - Outputs during reset: `out_valid` = 0, `xn` = 0, `yn` = 0, `zn` = 0.
  - A reset asserted mid-stream discards all in-flight samples, and no `out_valid` pulse follows for them.
  - The first sample accepted after deassertion emerges 10 cycles later.
- Back-to-back inputs produce back-to-back outputs in the same order, with no bubbles inserted.

## Configuration
- `CORDIC_ROUND_EN` defined: `xn`/`yn` are rounded to nearest by adding 2 (half an output LSB in guard-bit units) before dropping the 2 guard bits. Clamping is applied after rounding.
- `CORDIC_ROUND_EN` undefined: the guard bits are simply truncated (floor).
- Latency, interface and `zn` behaviour are identical in both builds.

## Test plan
- 45° with a single pulse: `z0` = 720 with `in_valid` for 1 cycle.
  - `out_valid` is high exactly 10 cycles later for exactly 1 cycle.
  - `xn` ≈ 92682 ±400, `yn` ≈ 92682 ±400, |`zn`| ≤ 6.
- 0°: `z0` = 0.
  - `xn` ≥ 130600 (131071 when clamped), `yn` ≤ 400.
- 90° and clamp: `z0` = 1440, then `z0` = 2000 on the next cycle.
  - Both results give `xn` ≤ 400 and `yn` ≥ 130600.
  - The two outputs are identical.
- Stream: `z0` = 0, 160, 320, …, 1440 (every 10°) on consecutive cycles.
  - Ten consecutive `out_valid` cycles, in order.
  - Each `xn`/`yn` is within 400 LSB of cos/sin·131072.
- Reset: assert `rst_n` = 0 mid-stream, asynchronously between edges.
  - Outputs and `out_valid` go to 0 immediately.
  - No stale results appear after release.
  - A new sample issued post-release returns at +10 cycles.
- Rounding: compare builds with and without `CORDIC_ROUND_EN` at 30° (`z0` = 480).
  - Results differ by at most 1 LSB.
  - The rounded build is within 400 LSB of 113512 (`xn`) and 65536 (`yn`).

Source files
------------

// File: rtl/cordic.sv
// rtl/cordic.sv - 10-stage pipelined rotation-mode CORDIC, degrees (Q7.4) to cos/sin (Q0.17)
// Build option: define CORDIC_ROUND_EN to round xn/yn to nearest instead of truncating.
module cordic #(
  parameter int N = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [10:0] z0,
  output logic        out_valid,
  output logic [16:0] xn,
  output logic [16:0] yn,
  output logic [10:0] zn
);
  localparam int XW = 20;
  localparam int ZW = 12;
  localparam logic signed [XW-1:0] X_INIT  = 20'sd318376;
  localparam logic signed [XW:0]   SAT_MAX = 21'sd524287;
  localparam logic signed [XW:0]   SAT_MIN = -21'sd524288;

  function automatic logic signed [ZW-1:0] atan_lut(input int i);
    case (i)
      0:       atan_lut = 12'sd720;
      1:       atan_lut = 12'sd425;
      2:       atan_lut = 12'sd225;
      3:       atan_lut = 12'sd114;
      4:       atan_lut = 12'sd57;
      5:       atan_lut = 12'sd29;
      6:       atan_lut = 12'sd14;
      7:       atan_lut = 12'sd7;
      8:       atan_lut = 12'sd4;
      9:       atan_lut = 12'sd2;
      default: atan_lut = 12'sd0;
    endcase
  endfunction

  // The vector magnitude ends within an LSB of 1.0, so sums saturate rather than wrap.
  function automatic logic signed [XW-1:0] sat(input logic signed [XW:0] v);
    if (v > SAT_MAX)      sat = SAT_MAX[XW-1:0];
    else if (v < SAT_MIN) sat = SAT_MIN[XW-1:0];
    else                  sat = v[XW-1:0];
  endfunction

  function automatic logic [16:0] to_out(input logic signed [XW-1:0] v);
    logic signed [XW:0] r;
`ifdef CORDIC_ROUND_EN
    r = {v[XW-1], v} + 21'sd2;
`else
    r = {v[XW-1], v};
`endif
    if (r < 0)          to_out = '0;
    else if (r[XW-1])   to_out = '1;
    else                to_out = r[18:2];
  endfunction

  logic                 in_valid_q, in_valid_d;
  logic [N-1:0]         valid_q, valid_d;
  logic signed [ZW-1:0] z_in_q, z_in_d;
  logic signed [XW-1:0] x_q [N];
  logic signed [XW-1:0] x_d [N];
  logic signed [XW-1:0] y_q [N];
  logic signed [XW-1:0] y_d [N];
  logic signed [ZW-1:0] z_q [N];
  logic signed [ZW-1:0] z_d [N];
  logic signed [XW-1:0] xs, ys, xsh, ysh;
  logic signed [ZW-1:0] zs;

  always_comb begin
    in_valid_d = in_valid;
    z_in_d     = (z0 > 11'd1440) ? 12'sd1440 : $signed({1'b0, z0});
    valid_d    = {valid_q[N-2:0], in_valid_q};
    xs  = '0;
    ys  = '0;
    zs  = '0;
    xsh = '0;
    ysh = '0;
    for (int i = 0; i < N; i++) begin
      if (i == 0) begin
        xs = X_INIT;
        ys = '0;
        zs = z_in_q;
      end else begin
        xs = x_q[i-1];
        ys = y_q[i-1];
        zs = z_q[i-1];
      end
      xsh = xs >>> i;
      ysh = ys >>> i;
      if (!zs[ZW-1]) begin
        x_d[i] = sat({xs[XW-1], xs} - {ysh[XW-1], ysh});
        y_d[i] = sat({ys[XW-1], ys} + {xsh[XW-1], xsh});
        z_d[i] = zs - atan_lut(i);
      end else begin
        x_d[i] = sat({xs[XW-1], xs} + {ysh[XW-1], ysh});
        y_d[i] = sat({ys[XW-1], ys} - {xsh[XW-1], xsh});
        z_d[i] = zs + atan_lut(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid_q <= 1'b0;
      valid_q    <= '0;
      z_in_q     <= '0;
      x_q        <= '{default: '0};
      y_q        <= '{default: '0};
      z_q        <= '{default: '0};
    end else begin
      in_valid_q <= in_valid_d;
      valid_q    <= valid_d;
      z_in_q     <= z_in_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
    end
  end

  assign out_valid = valid_q[N-1];
  assign xn        = to_out(x_q[N-1]);
  assign yn        = to_out(y_q[N-1]);
  assign zn        = z_q[N-1][10:0];
endmodule

// File: tb/tb_cordic.sv
// tb/tb_cordic.sv - directed self-checking bench for cordic
// Drives inputs 1ns after the rising edge and samples outputs at the same point.
module tb_cordic;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [10:0] z0;
  logic        out_valid;
  logic [16:0] xn;
  logic [16:0] yn;
  logic [10:0] zn;

  int total = 0;
  int bad   = 0;

  logic [16:0] cx, cy, ax, ay, bx, by;
  logic [10:0] cz, az, bz;
  int          stale;

  int exp_c [10] = '{131072, 129081, 123168, 113512, 100407, 84251, 65536, 44829, 22760, 0};
  int exp_s [10] = '{0, 22760, 44829, 65536, 84251, 100407, 113512, 123168, 129081, 131072};

  cordic #(.N(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .z0       (z0),
    .out_valid(out_valid),
    .xn       (xn),
    .yn       (yn),
    .zn       (zn)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic in_range(input string tag, input logic signed [31:0] obs,
                          input logic signed [31:0] lo, input logic signed [31:0] hi);
    logic ok;
    ok = !$isunknown(obs) && (obs >= lo) && (obs <= hi);
    total++;
    assert (ok === 1'b1) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=[%0d..%0d]", tag, obs, lo, hi);
    end
  endtask

  // Issue one sample and check out_valid timing around the +10 cycle result.
  task automatic single(input logic [10:0] z, input string tag,
                        output logic [16:0] x, output logic [16:0] y, output logic [10:0] zr);
    x = '0;
    y = '0;
    zr = '0;
    in_valid = 1'b1;
    z0 = z;
    step();
    in_valid = 1'b0;
    z0 = '0;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k == 9)  check({tag, "_valid_early"}, 32'(out_valid), 32'd0);
      if (k == 10) begin
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        x = xn;
        y = yn;
        zr = zn;
      end
      if (k == 11) check({tag, "_valid_late"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    z0 = '0;
    repeat (3) step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_xn", 32'(xn), 32'd0);
    check("rst_yn", 32'(yn), 32'd0);
    check("rst_zn", 32'(zn), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    single(11'd720, "deg45", cx, cy, cz);
    in_range("deg45_xn", 32'(cx), 92282, 93082);
    in_range("deg45_yn", 32'(cy), 92282, 93082);
    in_range("deg45_zn", 32'($signed(cz)), -6, 6);

    single(11'd0, "deg0", cx, cy, cz);
    in_range("deg0_xn", 32'(cx), 130600, 131071);
    in_range("deg0_yn", 32'(cy), 0, 400);

    in_valid = 1'b1;
    z0 = 11'd1440;
    step();
    z0 = 11'd2000;
    step();
    in_valid = 1'b0;
    z0 = '0;
    repeat (8) step();
    check("deg90_valid_early", 32'(out_valid), 32'd0);
    step();
    check("deg90_valid", 32'(out_valid), 32'd1);
    ax = xn; ay = yn; az = zn;
    step();
    check("clamp_valid", 32'(out_valid), 32'd1);
    bx = xn; by = yn; bz = zn;
    step();
    check("clamp_valid_late", 32'(out_valid), 32'd0);
    in_range("deg90_xn", 32'(ax), 0, 400);
    in_range("deg90_yn", 32'(ay), 130600, 131071);
    in_range("clamp_xn", 32'(bx), 0, 400);
    in_range("clamp_yn", 32'(by), 130600, 131071);
    check("clamp_same_xn", 32'(bx), 32'(ax));
    check("clamp_same_yn", 32'(by), 32'(ay));
    check("clamp_same_zn", 32'(bz), 32'(az));

    for (int k = 0; k <= 20; k++) begin
      if (k < 10) begin
        in_valid = 1'b1;
        z0 = 11'(160 * k);
      end else begin
        in_valid = 1'b0;
        z0 = '0;
      end
      step();
      if (k == 9 || k == 20) begin
        check($sformatf("stream_idle_%0d", k), 32'(out_valid), 32'd0);
      end else if (k >= 10) begin
        check($sformatf("stream_valid_%0d", k - 10), 32'(out_valid), 32'd1);
        in_range($sformatf("stream_xn_%0d", k - 10), 32'(xn), exp_c[k-10] - 400, exp_c[k-10] + 400);
        in_range($sformatf("stream_yn_%0d", k - 10), 32'(yn), exp_s[k-10] - 400, exp_s[k-10] + 400);
      end
    end

    single(11'd480, "deg30", cx, cy, cz);
    in_range("deg30_xn", 32'(cx), 113112, 113912);
    in_range("deg30_yn", 32'(cy), 65136, 65936);

    for (int k = 0; k <= 12; k++) begin
      in_valid = 1'b1;
      z0 = 11'd480;
      step();
    end
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_xn", 32'(xn), 32'd0);
    check("async_rst_yn", 32'(yn), 32'd0);
    check("async_rst_zn", 32'(zn), 32'd0);
    in_valid = 1'b0;
    z0 = '0;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (out_valid !== 1'b0) stale++;
    end
    check("no_stale_after_rst", 32'(stale), 32'd0);

    single(11'd160, "post_rst", cx, cy, cz);
    in_range("post_rst_xn", 32'(cx), 128681, 129481);
    in_range("post_rst_yn", 32'(cy), 22360, 23160);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
